pipelined_addsub: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the 8-bit combinational RCA.

---
 rtl/pipelined_addsub.sv | 90 +++++++++
 tb/tb_pipelined_addsub.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: one CW-bit carry chunk per stage,
// global-stall valid/ready flow control, carry/overflow/zero flags at the output.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = WIDTH / STAGES;

   // Handshake: a beat moves into stage 0 on in_valid & in_ready and leaves on
   // out_valid & out_ready; advance=0 freezes every stage at once.
   logic             advance;
   logic [STAGES-1:0] v;
   logic [STAGES-1:0] rc;
   logic [STAGES-1:0] nc;
   logic [WIDTH-1:0]  ra [STAGES];
   logic [WIDTH-1:0]  rb [STAGES];
   logic [WIDTH-1:0]  rs [STAGES];
   logic [WIDTH-1:0]  ns [STAGES];
   logic              msb_c;

   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;

   // Stage k ripples only its own chunk; the running carry lives in nc[k].
   always_comb begin
      msb_c = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         ns[k] = rs[k];
         nc[k] = rc[k];
         for (int i = 0; i < CW; i++) begin
            if (k * CW + i == WIDTH - 1) msb_c = nc[k];
            ns[k][k*CW+i] = ra[k][k*CW+i] ^ rb[k][k*CW+i] ^ nc[k];
            nc[k] = (ra[k][k*CW+i] & rb[k][k*CW+i]) |
                    ((ra[k][k*CW+i] ^ rb[k][k*CW+i]) & nc[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v         <= '0;
         rc        <= '0;
         out_valid <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            ra[k] <= '0;
            rb[k] <= '0;
            rs[k] <= '0;
         end
      end else if (advance) begin
         v[0]  <= in_valid;
         ra[0] <= a;
         rb[0] <= sub ? ~b : b;
         rs[0] <= '0;
         rc[0] <= sub ? ~cin : cin;
         for (int k = 1; k < STAGES; k++) begin
            v[k]  <= v[k-1];
            ra[k] <= ra[k-1];
            rb[k] <= rb[k-1];
            rs[k] <= ns[k-1];
            rc[k] <= nc[k-1];
         end
         out_valid <= v[STAGES-1];
         s         <= ns[STAGES-1];
         cout      <= nc[STAGES-1];
         ovf       <= msb_c ^ nc[STAGES-1];
         zero      <= ~|ns[STAGES-1];
      end
   end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: an 8-bit and a 32-bit instance, directed and
// model-driven beats, expected results queued at accept and checked at the output.
module tb_pipelined_addsub;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic out_ready = 1'b1;
   logic rand_ready = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_out32 = 0;
   int   acc_edges = 0;

   logic        in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, sub8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, s8;
   logic        out_valid8, cout8, ovf8, zero8;
   logic        in_valid32 = 1'b0, in_ready32, cin32 = 1'b0, sub32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0, s32;
   logic        out_valid32, cout32, ovf32, zero32;

   logic [10:0] exp8_q[$];
   int          acc8_q[$];
   logic [34:0] exp32_q[$];

   logic        hold_pend = 1'b0;
   logic [34:0] hold_val;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_addsub #(.WIDTH(8), .STAGES(4)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
      .out_ready(out_ready), .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8));

   pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a32), .b(b32), .cin(cin32), .sub(sub32), .out_valid(out_valid32),
      .out_ready(out_ready), .s(s32), .cout(cout32), .ovf(ovf32), .zero(zero32));

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic logic [34:0] model32(input logic [31:0] x, input logic [31:0] y,
                                           input logic c, input logic sb);
      logic [32:0] full;
      logic [31:0] r32;
      logic        co;
      longint      sx, sy, cc, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      cc = longint'(c);
      if (sb) begin
         r32 = x - y - 32'(c);
         co  = ({1'b0, x} >= ({1'b0, y} + 33'(c)));
         r   = sx - sy - cc;
      end else begin
         full = {1'b0, x} + {1'b0, y} + 33'(c);
         r32  = full[31:0];
         co   = full[32];
         r    = sx + sy + cc;
      end
      return {r32, co, (r > 64'sd2147483647) || (r < -64'sd2147483648), r32 == 32'd0};
   endfunction

   task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic c,
                        input logic sb, input logic [10:0] e);
      logic rdy;
      int   t = 0;
      a8 = x; b8 = y; cin8 = c; sub8 = sb; in_valid8 = 1'b1;
      forever begin
         @(negedge clk); rdy = in_ready8;
         @(posedge clk);
         if (rdy) break;
         if (++t > 200) break;
      end
      if (rdy) begin exp8_q.push_back(e); acc8_q.push_back(cyc + 1); end
      else chk("send8_timeout", 64'd0, 64'd1);
      #1 in_valid8 = 1'b0;
   endtask

   task automatic send32(input logic [31:0] x, input logic [31:0] y, input logic c,
                         input logic sb, input logic [34:0] e);
      logic rdy;
      int   t = 0;
      a32 = x; b32 = y; cin32 = c; sub32 = sb; in_valid32 = 1'b1;
      forever begin
         @(negedge clk); rdy = in_ready32;
         @(posedge clk);
         acc_edges++;
         if (rdy) break;
         if (++t > 200) break;
      end
      if (rdy) exp32_q.push_back(e);
      else chk("send32_timeout", 64'd0, 64'd1);
      #1 in_valid32 = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp8_q.size() != 0 || exp32_q.size() != 0) && t < 500) begin
         @(posedge clk); #1; t++;
      end
      chk("drain_empty", 64'(exp8_q.size() + exp32_q.size()), 64'd0);
   endtask

   // Output monitors: the transfer happens at the coming rising edge.
   always @(negedge clk) begin
      if (!rst && out_valid8 && out_ready) begin
         if (exp8_q.size() == 0) chk("dut8_unexpected", 64'd1, 64'd0);
         else begin
            chk("dut8_result", {s8, cout8, ovf8, zero8}, exp8_q.pop_front());
            chk("dut8_latency", 64'(cyc - acc8_q.pop_front()), 64'd4);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && hold_pend && out_valid32)
         chk("dut32_stall_hold", {s32, cout32, ovf32, zero32}, hold_val);
      hold_pend = !rst && out_valid32 && !out_ready;
      hold_val  = {s32, cout32, ovf32, zero32};
      if (!rst && out_valid32 && out_ready) begin
         n_out32++;
         if (exp32_q.size() == 0) chk("dut32_unexpected", 64'd1, 64'd0);
         else chk("dut32_result", {s32, cout32, ovf32, zero32}, exp32_q.pop_front());
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x, y;
      logic        c, sb;
      int          snap;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {out_valid8, out_valid32}, 64'd0);
      chk("rst_s32", s32, 64'd0);
      chk("rst_flags", {cout8, ovf8, zero8, cout32, ovf32, zero32}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", {in_ready8, in_ready32}, 64'd3);
      @(posedge clk); #1;

      // 8-bit directed vectors: {s, cout, ovf, zero}
      send8(8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0});
      send8(8'h05, 8'h05, 1'b0, 1'b1, {8'h00, 1'b1, 1'b0, 1'b1});
      send8(8'h00, 8'h01, 1'b0, 1'b1, {8'hFF, 1'b0, 1'b0, 1'b0});
      send8(8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1, 1'b0});
      send8(8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1});
      send8(8'h10, 8'h0F, 1'b1, 1'b1, {8'h00, 1'b1, 1'b0, 1'b1});
      send8(8'h10, 8'h0F, 1'b1, 1'b0, {8'h20, 1'b0, 1'b0, 1'b0});

      // 32-bit directed vectors
      send32(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, {32'h0, 1'b1, 1'b0, 1'b1});
      send32(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, {32'h80000000, 1'b0, 1'b1, 1'b0});
      send32(32'h80000000, 32'h1, 1'b0, 1'b1, {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0});
      send32(32'h00010000, 32'h1, 1'b0, 1'b1, {32'h0000FFFF, 1'b1, 1'b0, 1'b0});
      send32(32'h12345678, 32'h0FEDCBA8, 1'b0, 1'b0, {32'h22222220, 1'b0, 1'b0, 1'b0});
      drain();

      // 100 back-to-back beats, one accepted per cycle
      acc_edges = 0;
      for (int i = 0; i < 100; i++) begin
         x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
         send32(x, y, c, sb, model32(x, y, c, sb));
      end
      chk("b2b_accept_cycles", 64'(acc_edges), 64'd100);
      drain();

      // random downstream backpressure and input gaps
      rand_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         x = $urandom; y = (i % 4 == 0) ? x : $urandom;
         c = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
         send32(x, y, c, sb, model32(x, y, c, sb));
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      drain();
      rand_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // reset with three beats in flight
      snap = n_out32;
      send32(32'h1, 32'h2, 1'b0, 1'b0, {32'h3, 1'b0, 1'b0, 1'b0});
      send32(32'h5, 32'h3, 1'b0, 1'b1, {32'h2, 1'b1, 1'b0, 1'b0});
      send32(32'h0, 32'h0, 1'b0, 1'b0, {32'h0, 1'b0, 1'b0, 1'b1});
      rst = 1'b1;
      exp32_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk("flush_out_valid", out_valid32, 64'd0);
      chk("flush_outputs", {s32, cout32, ovf32, zero32}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      chk("flush_no_emerge", 64'(n_out32 - snap), 64'd0);

      // pipeline still works after the flush
      send32(32'hDEADBEEF, 32'h21524111, 1'b0, 1'b0, {32'h00000000, 1'b1, 1'b0, 1'b1});
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
